fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit_pkg.sv | 28 ++
 rtl/fwd_hazard_unit_src_sel.sv | 32 +++
 rtl/fwd_hazard_unit.sv | 129 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit: forward-select encodings,
// stall FSM states and the pipeline slot record.
package fwd_hazard_unit_pkg;

  localparam int RAW_MAX = 8;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // rd is zero-extended to RAW_MAX so one struct serves every RAW setting
  typedef struct packed {
    logic               valid;
    logic [RAW_MAX-1:0] rd;
    logic               wr_en;
    logic               mem_read;
  } slot_t;

  function automatic logic slot_writes(slot_t s, logic [RAW_MAX-1:0] r, logic zero_reg);
    return s.valid & s.wr_en & (s.rd == r) & !(zero_reg & (r == '0));
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_src_sel.sv
// Forward-select for one EX source operand: youngest matching writer wins,
// a matching load in MEM yields RF (the stall logic keeps that case away).
module fwd_src_mux_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ZERO_REG = 0
) (
  input  logic               rs_used_i,
  input  logic [RAW_MAX-1:0] rs_i,
  input  slot_t              mem_i,
  input  slot_t              wb_i,
  output logic [1:0]         sel_o
);
  localparam logic ZR = (ZERO_REG != 0);

  logic mem_hit, wb_hit;
  logic wb_ld_unused;

  assign wb_ld_unused = wb_i.mem_read;
  assign mem_hit = rs_used_i & slot_writes(mem_i, rs_i, ZR);
  assign wb_hit  = rs_used_i & slot_writes(wb_i, rs_i, ZR);

  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit) begin
      sel_o = mem_i.mem_read ? FWD_RF : FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX/MEM/WB shadow pipeline with operand forwarding selects and a load-use
// stall FSM; also counts stalled cycles with saturation.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int RAW      = 3,
  parameter int NSRC     = 2,
  parameter int ZERO_REG = 0,
  parameter int PCW      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [NSRC*RAW-1:0] id_rs,
  input  logic [NSRC-1:0]     id_rs_used,
  input  logic [RAW-1:0]      id_rd,
  input  logic                id_wr_en,
  input  logic                id_mem_read,
  input  logic                flush,
  output logic                stall,
  output logic [NSRC*2-1:0]   fwd_sel,
  output logic [PCW-1:0]      stall_cycles
);
  localparam logic ZR = (ZERO_REG != 0);

  slot_t                        ex_q, ex_d, mem_q, wb_q;
  logic [NSRC-1:0][RAW_MAX-1:0] id_rs_ext, ex_rs_q, ex_rs_d;
  logic [NSRC-1:0]              ex_rs_used_q, ex_rs_used_d;
  state_e                       state_q, state_d;
  logic [1:0]                   cnt_q, cnt_d;
  logic [PCW-1:0]               stall_cycles_q;
  logic                         hz_ex, hz_mem;
  logic [1:0]                   need;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign id_rs_ext[i] = RAW_MAX'(id_rs[i*RAW +: RAW]);

    fwd_src_mux_sel #(.ZERO_REG(ZERO_REG)) u_sel (
      .rs_used_i (ex_rs_used_q[i]),
      .rs_i      (ex_rs_q[i]),
      .mem_i     (mem_q),
      .wb_i      (wb_q),
      .sel_o     (fwd_sel[2*i +: 2])
    );
  end

  // Load-use distance: a load in EX needs two bubbles, a load in MEM one
  always_comb begin
    hz_ex  = 1'b0;
    hz_mem = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_valid && id_rs_used[i]) begin
        if (ex_q.mem_read && slot_writes(ex_q, id_rs_ext[i], ZR))   hz_ex  = 1'b1;
        if (mem_q.mem_read && slot_writes(mem_q, id_rs_ext[i], ZR)) hz_mem = 1'b1;
      end
    end
    need = hz_ex ? 2'd2 : (hz_mem ? 2'd1 : 2'd0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      RUN: begin
        stall = (need != 2'd0);
        if (need == 2'd2) begin
          state_d = STALL;
          cnt_d   = 2'd1;
        end
      end
      STALL: begin
        stall = 1'b1;
        if (cnt_q == 2'd1) begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
    endcase
    if (flush) begin
      stall   = 1'b0;
      state_d = RUN;
      cnt_d   = 2'd0;
    end
  end

  // A bubble only clears valid; the remaining EX fields keep their old contents
  always_comb begin
    ex_d         = ex_q;
    ex_d.valid   = 1'b0;
    ex_rs_d      = ex_rs_q;
    ex_rs_used_d = ex_rs_used_q;
    if (!stall && !flush) begin
      ex_d.valid    = id_valid;
      ex_d.rd       = RAW_MAX'(id_rd);
      ex_d.wr_en    = id_wr_en;
      ex_d.mem_read = id_mem_read;
      ex_rs_d       = id_rs_ext;
      ex_rs_used_d  = id_rs_used;
    end
  end

  always_ff @(posedge clk) begin
    ex_q         <= ex_d;
    mem_q        <= ex_q;
    wb_q         <= mem_q;
    ex_rs_q      <= ex_rs_d;
    ex_rs_used_q <= ex_rs_used_d;
    if (rst) begin
      ex_q.valid     <= 1'b0;
      mem_q.valid    <= 1'b0;
      wb_q.valid     <= 1'b0;
      state_q        <= RUN;
      cnt_q          <= 2'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (ZERO_REG 0 with a 2-bit counter,
// ZERO_REG 1 with a 16-bit counter) on shared stimulus, checked every cycle.
module tb_fwd_hazard_unit;
  localparam int RAW  = 5;
  localparam int NSRC = 3;

  typedef struct packed {
    logic        rst, vld;
    logic [14:0] rs;
    logic [2:0]  used;
    logic [4:0]  rd;
    logic        we, mr, fl;
    logic        st;
    logic [5:0]  f0, f1;
    logic [1:0]  s0;
    logic [15:0] s1;
  } vec_t;

  typedef struct packed {
    logic        st0, st1;
    logic [5:0]  f0, f1;
    logic [1:0]  s0;
    logic [15:0] s1;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, id_valid, id_wr_en, id_mem_read, flush;
  logic [NSRC*RAW-1:0] id_rs;
  logic [NSRC-1:0]     id_rs_used;
  logic [RAW-1:0]      id_rd;
  logic                stall0, stall1;
  logic [2*NSRC-1:0]   fwd0, fwd1;
  logic [1:0]          sc0;
  logic [15:0]         sc1;

  fwd_hazard_unit #(.RAW(RAW), .NSRC(NSRC), .ZERO_REG(0), .PCW(2)) u_z0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall0), .fwd_sel(fwd0), .stall_cycles(sc0)
  );

  fwd_hazard_unit #(.RAW(RAW), .NSRC(NSRC), .ZERO_REG(1), .PCW(16)) u_z1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall1), .fwd_sel(fwd1), .stall_cycles(sc1)
  );

  // Reference model, index z = ZERO_REG of the instance; slot 0=EX 1=MEM 2=WB
  bit   mv  [2][3];
  bit   mwe [2][3];
  bit   mmr [2][3];
  int   mrd [2][3];
  int   mers[2][NSRC];
  bit   meu [2][NSRC];
  bit   mst [2];
  int   mcnt[2];
  int   msc [2];
  bit   xst [2];
  int   xneed[2];
  exp_t sb_q[$];
  int   checks, errors, cyc;

  function automatic bit mw(int z, int k, int r);
    return mv[z][k] && mwe[z][k] && (mrd[z][k] == r) && !(z == 1 && r == 0);
  endfunction

  function automatic exp_t model_comb();
    exp_t       e;
    logic [5:0] f [2];
    for (int z = 0; z < 2; z++) begin
      int         n, r;
      logic [1:0] s;
      n = 0;
      f[z] = '0;
      for (int i = 0; i < NSRC; i++) begin
        s = 2'd0;
        r = mers[z][i];
        if (meu[z][i] && mw(z, 1, r)) s = mmr[z][1] ? 2'd0 : 2'd2;
        else if (meu[z][i] && mw(z, 2, r)) s = 2'd1;
        f[z][2*i +: 2] = s;
        if (id_valid && id_rs_used[i]) begin
          r = int'(id_rs[i*RAW +: RAW]);
          if (mmr[z][0] && mw(z, 0, r)) n = 2;
          else if (mmr[z][1] && mw(z, 1, r) && n == 0) n = 1;
        end
      end
      xneed[z] = n;
      xst[z]   = flush ? 1'b0 : (mst[z] ? 1'b1 : (n != 0));
    end
    e.st0 = xst[0];
    e.st1 = xst[1];
    e.f0  = f[0];
    e.f1  = f[1];
    e.s0  = 2'(msc[0]);
    e.s1  = 16'(msc[1]);
    return e;
  endfunction

  task automatic model_seq();
    for (int z = 0; z < 2; z++) begin
      for (int k = 2; k > 0; k--) begin
        mv[z][k]  = mv[z][k-1];
        mrd[z][k] = mrd[z][k-1];
        mwe[z][k] = mwe[z][k-1];
        mmr[z][k] = mmr[z][k-1];
      end
      if (!xst[z] && !flush) begin
        mv[z][0]  = id_valid;
        mrd[z][0] = int'(id_rd);
        mwe[z][0] = id_wr_en;
        mmr[z][0] = id_mem_read;
        for (int i = 0; i < NSRC; i++) begin
          mers[z][i] = int'(id_rs[i*RAW +: RAW]);
          meu[z][i]  = id_rs_used[i];
        end
      end else begin
        mv[z][0] = 1'b0;
      end
      if (flush) begin
        mst[z] = 1'b0; mcnt[z] = 0;
      end else if (!mst[z]) begin
        if (xneed[z] == 2) begin mst[z] = 1'b1; mcnt[z] = 1; end
      end else if (mcnt[z] == 1) begin
        mst[z] = 1'b0; mcnt[z] = 0;
      end else begin
        mcnt[z] = mcnt[z] - 1;
      end
      if (xst[z] && msc[z] < ((z == 0) ? 3 : 65535)) msc[z] = msc[z] + 1;
      if (rst) begin
        mv[z][0] = 1'b0; mv[z][1] = 1'b0; mv[z][2] = 1'b0;
        mst[z] = 1'b0; mcnt[z] = 0; msc[z] = 0;
      end
    end
  endtask

  function automatic vec_t mk(input bit r_, vl, input int a, b, c, input logic [2:0] u,
                              input int rd, input bit we, mr, fl, st,
                              input logic [5:0] f0, f1, input int s0, s1);
    vec_t v;
    v.rst = r_; v.vld = vl; v.rs = {5'(c), 5'(b), 5'(a)}; v.used = u; v.rd = 5'(rd);
    v.we = we; v.mr = mr; v.fl = fl; v.st = st; v.f0 = f0; v.f1 = f1;
    v.s0 = 2'(s0); v.s1 = 16'(s1);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = v.rst; id_valid = v.vld; id_rs = v.rs; id_rs_used = v.used;
    id_rd = v.rd; id_wr_en = v.we; id_mem_read = v.mr; flush = v.fl;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input bit hand);
    exp_t e;
    apply(v);
    sb_q.push_back(model_comb());
    @(negedge clk);
    e = sb_q.pop_front();
    chk("stall_z0", 32'(stall0), 32'(e.st0));
    chk("stall_z1", 32'(stall1), 32'(e.st1));
    chk("fwd_z0",   32'(fwd0),   32'(e.f0));
    chk("fwd_z1",   32'(fwd1),   32'(e.f1));
    chk("cnt_z0",   32'(sc0),    32'(e.s0));
    chk("cnt_z1",   32'(sc1),    32'(e.s1));
    if (hand) begin
      chk("vec_stall_z0", 32'(stall0), 32'(v.st));
      chk("vec_stall_z1", 32'(stall1), 32'(v.st));
      chk("vec_fwd_z0",   32'(fwd0),   32'(v.f0));
      chk("vec_fwd_z1",   32'(fwd1),   32'(v.f1));
      chk("vec_cnt_z0",   32'(sc0),    32'(v.s0));
      chk("vec_cnt_z1",   32'(sc1),    32'(v.s1));
    end
    @(posedge clk);
    model_seq();
    cyc++;
    #1;
  endtask

  initial begin
    vec_t tbl [36];
    vec_t v;
    checks = 0; errors = 0; cyc = 0;
    apply(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;

    //               rst vl  a  b  c  used    rd we mr fl  st  f0     f1     s0 s1
    tbl[0]  = mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 6'h00, 6'h00, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 6'h00, 6'h00, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 6'h00, 6'h00, 0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 3'b001, 2, 1, 0, 0, 0, 6'h00, 6'h00, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 6'h02, 6'h02, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 6'h00, 6'h00, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 3'b000, 5, 1, 0, 0, 0, 6'h00, 6'h00, 0, 0);
    tbl[7]  = mk(0, 1, 1, 0, 0, 3'b001, 2, 1, 0, 0, 0, 6'h00, 6'h00, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 6'h01, 6'h01, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 6'h00, 6'h00, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 6'h00, 6'h00, 0, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 3'b001, 2, 0, 0, 0, 0, 6'h00, 6'h00, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 6'h01, 6'h00, 0, 0);
    tbl[13] = mk(0, 1, 0, 0, 0, 3'b000, 3, 1, 1, 0, 0, 6'h00, 6'h00, 0, 0);
    tbl[14] = mk(0, 1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 1, 6'h00, 6'h00, 0, 0);
    tbl[15] = mk(0, 1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 1, 6'h00, 6'h00, 1, 1);
    tbl[16] = mk(0, 1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 0, 6'h00, 6'h00, 2, 2);
    tbl[17] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 6'h00, 6'h00, 2, 2);
    tbl[18] = mk(0, 1, 0, 0, 0, 3'b000, 3, 1, 1, 0, 0, 6'h00, 6'h00, 2, 2);
    tbl[19] = mk(0, 1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 1, 6'h00, 6'h00, 2, 2);
    tbl[20] = mk(0, 1, 3, 0, 0, 3'b001, 4, 1, 0, 1, 0, 6'h00, 6'h00, 3, 3);
    tbl[21] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 6'h00, 6'h00, 3, 3);
    tbl[22] = mk(0, 1, 0, 0, 0, 3'b000, 3, 1, 1, 0, 0, 6'h00, 6'h00, 3, 3);
    tbl[23] = mk(0, 1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 1, 6'h00, 6'h00, 3, 3);
    tbl[24] = mk(0, 1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 1, 6'h00, 6'h00, 3, 4);
    tbl[25] = mk(0, 1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 0, 6'h00, 6'h00, 3, 5);
    tbl[26] = mk(0, 1, 0, 0, 0, 3'b000, 6, 1, 1, 0, 0, 6'h00, 6'h00, 3, 5);
    tbl[27] = mk(0, 1, 0, 0, 0, 3'b000, 7, 1, 0, 0, 0, 6'h00, 6'h00, 3, 5);
    tbl[28] = mk(0, 1, 0, 6, 0, 3'b010, 8, 1, 0, 0, 1, 6'h00, 6'h00, 3, 5);
    tbl[29] = mk(0, 1, 0, 6, 0, 3'b010, 8, 1, 0, 0, 0, 6'h00, 6'h00, 3, 6);
    tbl[30] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 6'h00, 6'h00, 3, 6);
    tbl[31] = mk(0, 1, 0, 0, 0, 3'b000, 3, 1, 1, 0, 0, 6'h00, 6'h00, 3, 6);
    tbl[32] = mk(0, 1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 1, 6'h00, 6'h00, 3, 6);
    tbl[33] = mk(1, 1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 1, 6'h00, 6'h00, 3, 7);
    tbl[34] = mk(0, 1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 0, 6'h00, 6'h00, 0, 0);
    tbl[35] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 6'h00, 6'h00, 0, 0);

    for (int n = 0; n < 36; n++) step(tbl[n], 1'b1);

    // Random instruction stream; ID is mostly held while either instance stalls
    v = '0;
    for (int c = 0; c < 2500; c++) begin
      if (!(xst[0] || xst[1]) || $urandom_range(0, 9) == 0) begin
        v.vld  = ($urandom_range(0, 4) != 0);
        v.rs   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        v.used = 3'($urandom_range(0, 7));
        v.rd   = 5'($urandom_range(0, 7));
        v.we   = ($urandom_range(0, 3) != 0);
        v.mr   = ($urandom_range(0, 2) == 0);
      end
      v.rst = ($urandom_range(0, 199) == 0);
      v.fl  = ($urandom_range(0, 11) == 0);
      step(v, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
